// File: rtl/dmem_pkg.sv
// Shared constants and types for the MIPS data-memory responder.
// Array geometry, FSM state encoding and the write-buffer entry layout.
package dmem_pkg;

    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;

    typedef enum logic {
        CLEAR,
        SERVE
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbuf_t;

endpackage

// File: rtl/dmem_if.sv
// Core-side CEN/WEN/OEN/A data bus plus the preload valid/ready port.
// master = core/testbench side, slave = the responder.
interface dmem_if;
    import dmem_pkg::*;

    logic              CEN;
    logic              WEN;
    logic              OEN;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] D;
    logic [DATA_W-1:0] Q;
    logic              busy;
    logic              init_valid;
    logic              init_ready;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;

    modport master (
        output CEN, WEN, OEN, A, D, init_valid, init_addr, init_data,
        input  Q, busy, init_ready
    );

    modport slave (
        input  CEN, WEN, OEN, A, D, init_valid, init_addr, init_data,
        output Q, busy, init_ready
    );

endinterface

// File: rtl/dmem_wbuf.sv
// One-entry posted write buffer with read-after-write forwarding.
// Latency: loads at the edge, commits at the following edge; forwarding is combinational.
// Backpressure: none; a load always wins, a valid entry always drains next edge.
module dmem_wbuf
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output wbuf_t             commit
);

    wbuf_t wb_q;

    // The entry is handed to the array every cycle it is valid, so it only lives one cycle
    // unless a fresh write replaces it at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else if (ld) begin
            wb_q <= '{valid: 1'b1, addr: ld_addr, data: ld_data};
        end else begin
            wb_q.valid <= 1'b0;
        end
    end

    assign commit   = wb_q;
    assign fwd_hit  = wb_q.valid && (wb_q.addr == rd_addr);
    assign fwd_data = wb_q.data;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: 128x32 array, combinational reads, posted writes, post-reset clear.
// Latency: reads 0 cycles; writes visible via forwarding immediately, in the array one edge later.
// Backpressure: init_ready low while clearing or while the core owns the bus this cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_if.slave            bus,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              serve;
    logic              rd_en;
    logic              core_wr;
    logic              init_xfer;
    logic              ld;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    wbuf_t             commit;

    assign serve          = (state_q == SERVE);
    assign rd_en          = serve && !bus.CEN && bus.WEN && !bus.OEN;
    assign core_wr        = serve && !bus.CEN && !bus.WEN;
    assign bus.init_ready = serve && bus.CEN;
    assign init_xfer      = bus.init_valid && bus.init_ready;
    assign bus.busy       = !serve;

    // init_ready already excludes core cycles, so the two load sources never collide.
    assign ld      = core_wr || init_xfer;
    assign ld_addr = core_wr ? bus.A : bus.init_addr;
    assign ld_data = core_wr ? bus.D : bus.init_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = SERVE;
                end
            end
            SERVE:   state_d = SERVE;
            default: state_d = CLEAR;
        endcase
    end

    // The buffer is never loaded while clearing, so the clear walk owns the write port then.
    always_ff @(posedge clk) begin
        if (!serve) begin
            mem[clr_ptr_q] <= '0;
        end else if (commit.valid) begin
            mem[commit.addr] <= commit.data;
        end
    end

    dmem_wbuf u_wbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (ld),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .rd_addr  (bus.A),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .commit   (commit)
    );

    assign bus.Q = rd_en ? (fwd_hit ? fwd_data : mem[bus.A]) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_en && (rd_count != '1)) begin
                rd_count <= rd_count + 1'b1;
            end
            if (core_wr && (wr_count != '1)) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written corner sequences and random traffic
// checked against a word-level memory model; a second 4-bit-counter instance mirrors the same bus.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_if bus ();
    dmem_if sbus ();

    logic [15:0] rd_count, wr_count;
    logic [3:0]  s_rd, s_wr;

    dmem_responder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .rd_count(rd_count), .wr_count(wr_count)
    );

    dmem_responder #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(sbus), .rd_count(s_rd), .wr_count(s_wr)
    );

    assign sbus.CEN        = bus.CEN;
    assign sbus.WEN        = bus.WEN;
    assign sbus.OEN        = bus.OEN;
    assign sbus.A          = bus.A;
    assign sbus.D          = bus.D;
    assign sbus.init_valid = bus.init_valid;
    assign sbus.init_addr  = bus.init_addr;
    assign sbus.init_data  = bus.init_data;

    int n_cmp = 0;
    int n_err = 0;

    // Word-level model: a write is in m_mem from its edge on, which is what the core observes.
    logic [31:0] m_mem [DEPTH];
    int          m_clear;
    int          m_rd;
    int          m_wr;
    bit          pend;

    typedef struct {
        logic        cen, wen, oen;
        logic [6:0]  a;
        logic [31:0] d;
        logic        iv;
        logic [6:0]  ia;
        logic [31:0] id;
        logic [31:0] q;
        logic        ir;
        int          rd, wr;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [31:0] satv(int v, int w);
        int mx = (1 << w) - 1;
        return 32'((v > mx) ? mx : v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic cen, input logic wen, input logic oen, input logic [6:0] a,
                         input logic [31:0] d, input logic iv, input logic [6:0] ia,
                         input logic [31:0] id);
        bus.CEN = cen; bus.WEN = wen; bus.OEN = oen; bus.A = a; bus.D = d;
        bus.init_valid = iv; bus.init_addr = ia; bus.init_data = id;
    endtask

    task automatic sample_model();
        bit          eb, erd;
        logic [31:0] eq;
        eb  = (m_clear > 0);
        erd = !eb && !bus.CEN && bus.WEN && !bus.OEN;
        eq  = erd ? m_mem[bus.A] : 32'h0;
        chk("q", bus.Q, eq);
        chk("busy", 32'(bus.busy), 32'(eb));
        chk("init_ready", 32'(bus.init_ready), 32'(!eb && bus.CEN));
        chk("rd_count", 32'(rd_count), satv(m_rd, 16));
        chk("wr_count", 32'(wr_count), satv(m_wr, 16));
        chk("sat_rd_count", 32'(s_rd), satv(m_rd, 4));
        chk("sat_wr_count", 32'(s_wr), satv(m_wr, 4));
    endtask

    task automatic advance();
        pend = bus.init_valid && !((m_clear == 0) && bus.CEN);
        if (m_clear > 0) begin
            m_clear--;
        end else begin
            if (!bus.CEN && !bus.WEN) begin
                m_mem[bus.A] = bus.D;
                m_wr++;
            end else if (bus.CEN && bus.init_valid) begin
                m_mem[bus.init_addr] = bus.init_data;
            end
            if (!bus.CEN && bus.WEN && !bus.OEN) m_rd++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        sample_model();
        advance();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        m_clear = DEPTH;
        m_rd    = 0;
        m_wr    = 0;
        pend    = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        #2;
        chk("rst_q", bus.Q, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h1);
        chk("rst_init_ready", 32'(bus.init_ready), 32'h0);
        chk("rst_rd_count", 32'(rd_count), 32'h0);
        chk("rst_wr_count", 32'(wr_count), 32'h0);
        chk("rst_sat_rd", 32'(s_rd), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        //          cen  wen  oen  a  d             iv   ia d         q             ir   rd wr
        tbl[0]  = '{1'b0,1'b0,1'b1,3, 32'hDEADBEEF, 1'b0,0, 0,        32'h0,        1'b0,0, 0};
        tbl[1]  = '{1'b0,1'b1,1'b0,3, 0,            1'b0,0, 0,        32'hDEADBEEF, 1'b0,0, 1};
        tbl[2]  = '{1'b0,1'b1,1'b0,3, 0,            1'b0,0, 0,        32'hDEADBEEF, 1'b0,1, 1};
        tbl[3]  = '{1'b0,1'b0,1'b0,7, 32'h1,        1'b0,0, 0,        32'h0,        1'b0,2, 1};
        tbl[4]  = '{1'b0,1'b0,1'b0,7, 32'h2,        1'b0,0, 0,        32'h0,        1'b0,2, 2};
        tbl[5]  = '{1'b0,1'b1,1'b0,7, 0,            1'b0,0, 0,        32'h2,        1'b0,2, 3};
        tbl[6]  = '{1'b1,1'b1,1'b0,0, 0,            1'b0,0, 0,        32'h0,        1'b1,3, 3};
        tbl[7]  = '{1'b0,1'b1,1'b1,7, 0,            1'b0,0, 0,        32'h0,        1'b0,3, 3};
        tbl[8]  = '{1'b0,1'b1,1'b0,9, 0,            1'b1,9, 32'hCAFE, 32'h0,        1'b0,3, 3};
        tbl[9]  = '{1'b0,1'b1,1'b0,9, 0,            1'b1,9, 32'hCAFE, 32'h0,        1'b0,4, 3};
        tbl[10] = '{1'b0,1'b1,1'b0,9, 0,            1'b1,9, 32'hCAFE, 32'h0,        1'b0,5, 3};
        tbl[11] = '{1'b1,1'b1,1'b0,9, 0,            1'b1,9, 32'hCAFE, 32'h0,        1'b1,6, 3};
        tbl[12] = '{1'b0,1'b1,1'b0,9, 0,            1'b0,0, 0,        32'hCAFE,     1'b0,6, 3};
        tbl[13] = '{1'b0,1'b1,1'b0,9, 0,            1'b0,0, 0,        32'hCAFE,     1'b0,7, 3};
        tbl[14] = '{1'b1,1'b1,1'b0,3, 0,            1'b0,0, 0,        32'h0,        1'b1,8, 3};
        tbl[15] = '{1'b0,1'b1,1'b0,7, 0,            1'b0,0, 0,        32'h2,        1'b0,8, 3};

        // Reset release with a read held on the bus the whole time.
        drive(1'b0, 1'b1, 1'b0, 7'd5, 32'h0, 1'b0, 7'd0, 32'h0);
        do_reset();
        repeat (DEPTH) step();
        @(negedge clk);
        chk("clear_done_busy", 32'(bus.busy), 32'h0);
        chk("clear_word5", bus.Q, 32'h0);
        sample_model();
        advance();

        // Directed table from fresh counters.
        drive(1'b1, 1'b1, 1'b0, 7'd0, 32'h0, 1'b0, 7'd0, 32'h0);
        do_reset();
        repeat (DEPTH) step();
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].cen, tbl[i].wen, tbl[i].oen, tbl[i].a, tbl[i].d,
                  tbl[i].iv, tbl[i].ia, tbl[i].id);
            @(negedge clk);
            chk($sformatf("tbl%0d_q", i), bus.Q, tbl[i].q);
            chk($sformatf("tbl%0d_ir", i), 32'(bus.init_ready), 32'(tbl[i].ir));
            chk($sformatf("tbl%0d_rd", i), 32'(rd_count), 32'(tbl[i].rd));
            chk($sformatf("tbl%0d_wr", i), 32'(wr_count), 32'(tbl[i].wr));
            sample_model();
            advance();
        end

        // Reset lands between the write edge and its commit edge.
        drive(1'b0, 1'b0, 1'b1, 7'd10, 32'h55, 1'b0, 7'd0, 32'h0);
        step();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 7'd10, 32'h0, 1'b0, 7'd0, 32'h0);
        repeat (DEPTH) step();
        @(negedge clk);
        chk("midrst_q", bus.Q, 32'h0);
        chk("midrst_rd", 32'(rd_count), 32'h0);
        chk("midrst_wr", 32'(wr_count), 32'h0);
        sample_model();
        advance();

        // Saturation of the 4-bit read counter.
        repeat (20) step();
        @(negedge clk);
        chk("sat_rd_20", 32'(s_rd), 32'hF);
        chk("full_rd_21", 32'(rd_count), 32'd21);
        sample_model();
        advance();
        repeat (5) step();
        @(negedge clk);
        chk("sat_rd_hold", 32'(s_rd), 32'hF);
        sample_model();
        advance();

        // Random traffic; a refused preload keeps its fields until accepted.
        for (int n = 0; n < 2000; n++) begin
            logic       r_cen, r_iv;
            logic [6:0] r_a, r_ia;
            logic [31:0] r_id;
            r_cen = ($urandom_range(0, 9) < 4);
            r_a   = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 15));
            if (pend) begin
                r_iv = 1'b1; r_ia = bus.init_addr; r_id = bus.init_data;
            end else begin
                r_iv = $urandom_range(0, 2) == 0;
                r_ia = 7'($urandom_range(0, 15));
                r_id = $urandom;
            end
            drive(r_cen, 1'($urandom), ($urandom_range(0, 4) == 0), r_a, $urandom,
                  r_iv, r_ia, r_id);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
